// File: rtl/axis_event_packetizer_pkg.sv
// Shared definitions for the AXI-Stream event packetizer.
// Holds the default configuration, the helpers that derive the timestamp and
// FIFO level widths from the module parameters, and the tkeep fill bit.
// Optional feature macro used by the top level: PACKETIZER_DROP_CNT_EN.
package packetizer_pkg;

  localparam int DEF_NCH     = 4;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_DEPTH   = 1024;
  localparam int DEF_PKT_W   = 32;
  localparam int DEF_PKT_LEN = 256;
  localparam int DROP_W      = 32;

  // Every byte lane carries data, so tkeep is this bit replicated.
  localparam logic TKEEP_BIT = 1'b1;

  // The timestamp fills the low part of the word and the edge mask sits on
  // top of it: word = {mask[NCH-1:0], ts[TS_W-1:0]}.
  function automatic int calc_ts_w(input int data_w, input int nch);
    return data_w - nch;
  endfunction

  // The level needs one extra bit so that a full FIFO (DEPTH) is representable.
  function automatic int calc_lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_event_packetizer_sfifo_fwft.sv
// sfifo_fwft: single-clock first-word-fall-through FIFO.
// Ports:
//   clk, reset      posedge clock, synchronous active-high reset (empties FIFO)
//   wr_en, din      write request and data; full reports no free slot
//   rd_en, dout     pop request; dout already shows the head word when !empty
//   empty           no word stored
//   level           number of stored words (0..DEPTH)
// A write while full is accepted when a pop happens in the same cycle.
module sfifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  always_comb begin
    do_rd    = rd_en & ~empty;
    // A pop in the same cycle frees the slot the write needs.
    do_wr    = wr_en & (~full | do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + 1'b1;
    end else if (!do_wr && do_rd) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!reset && do_wr) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // DEPTH is a power of two, so the count MSB alone marks a full FIFO.
  assign full  = count_q[AW];
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];
  assign level = count_q;

endmodule

// File: rtl/axis_event_packetizer.sv
// axis_event_packetizer: multi-channel event timestamper with AXI-Stream output.
// Rising edges on event_i (gated by enable_i and ch_en_i) form one word
// {edge mask, timestamp}; words go through an FWFT FIFO and leave as an
// AXI-Stream with TLAST every pkt_len words.
// Ports:
//   clk, reset               posedge clock, synchronous active-high reset
//   event_i, enable_i        event levels, global capture/timestamp enable
//   ch_en_i                  per-channel capture enable
//   pkt_len_i                words per packet (0 behaves as 1)
//   clear_ovf_i              clears overflow_o / drop_cnt_o
//   m_axis_*                 AXI-Stream master (tkeep constant all ones)
//   level_o                  FIFO occupancy
//   overflow_o               sticky flag, at least one word dropped
//   drop_cnt_o               dropped word count, only with PACKETIZER_DROP_CNT_EN,
//                            otherwise tied to zero
module axis_event_packetizer
  import packetizer_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int PKT_W       = DEF_PKT_W,
  parameter int DEF_PKT_LEN = packetizer_pkg::DEF_PKT_LEN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NCH-1:0]               event_i,
  input  logic                         enable_i,
  input  logic [NCH-1:0]               ch_en_i,
  input  logic [PKT_W-1:0]             pkt_len_i,
  input  logic                         clear_ovf_i,
  output logic [DATA_W-1:0]            m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [DATA_W/8-1:0]          m_axis_tkeep,
  output logic [calc_lvl_w(DEPTH)-1:0] level_o,
  output logic                         overflow_o,
  output logic [DROP_W-1:0]            drop_cnt_o
);

  localparam int TS_W = calc_ts_w(DATA_W, NCH);

  logic [NCH-1:0]    event_q;
  logic [NCH-1:0]    edge_mask;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [PKT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [PKT_W-1:0]  pkt_len_q, pkt_len_d;
  logic              overflow_q, overflow_d;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] wr_word;
  logic              wr_req, pop, drop, last_beat;

  sfifo_fwft #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (wr_req),
    .din   (wr_word),
    .full  (fifo_full),
    .rd_en (pop),
    .dout  (m_axis_tdata),
    .empty (fifo_empty),
    .level (level_o)
  );

  always_comb begin
    edge_mask = enable_i ? (event_i & ~event_q & ch_en_i) : '0;
    wr_req    = |edge_mask;
    wr_word   = {edge_mask, ts_q};
    pop       = ~fifo_empty & m_axis_tready;
    drop      = wr_req & fifo_full & ~pop;
    ts_d      = enable_i ? ts_q + 1'b1 : ts_q;
    // pkt_len_q is never zero, so the subtraction cannot underflow.
    last_beat = ~fifo_empty & (beat_cnt_q == pkt_len_q - 1'b1);

    beat_cnt_d = beat_cnt_q;
    if (pop) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
    end

    // The length is only picked up between packets so a running packet
    // always completes with the length it started with.
    pkt_len_d = pkt_len_q;
    if (beat_cnt_q == '0) begin
      pkt_len_d = (pkt_len_i == '0) ? PKT_W'(1) : pkt_len_i;
    end

    // A drop in the same cycle as a clear wins, so no drop goes unreported.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_ovf_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // Tracked through reset too, so a level held high across reset is no edge.
    event_q <= event_i;
    if (reset) begin
      ts_q       <= '0;
      beat_cnt_q <= '0;
      pkt_len_q  <= PKT_W'(DEF_PKT_LEN);
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_len_q  <= pkt_len_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef PACKETIZER_DROP_CNT_EN
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  // A clear restarts the count; a drop in the same cycle is counted after it.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear_ovf_i) begin
      drop_cnt_d = DROP_W'(drop);
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tlast  = last_beat;
  assign m_axis_tkeep  = {(DATA_W/8){TKEEP_BIT}};
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_axis_event_packetizer.sv
// Directed testbench for axis_event_packetizer (NCH=4, DATA_W=64, DEPTH=16).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_axis_event_packetizer;

  localparam int NCH   = 4;
  localparam int DATA_W = 64;
  localparam int DEPTH = 16;
  localparam int PKT_W = 32;
  localparam int TS_W  = DATA_W - NCH;
`ifdef PACKETIZER_DROP_CNT_EN
  localparam logic [31:0] EXP_DROPS = 32'd3;
`else
  localparam logic [31:0] EXP_DROPS = 32'd0;
`endif

  logic              clk;
  logic              reset;
  logic [NCH-1:0]    event_i;
  logic              enable_i;
  logic [NCH-1:0]    ch_en_i;
  logic [PKT_W-1:0]  pkt_len_i;
  logic              clear_ovf_i;
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W/8-1:0] tkeep;
  logic [4:0]        level;
  logic              overflow;
  logic [31:0]       drop_cnt;

  int                vectors = 0;
  int                miscompares = 0;
  logic [TS_W-1:0]   ts_model;
  logic [DATA_W-1:0] exp_word;
  logic [DATA_W-1:0] exp_q[$];

  axis_event_packetizer #(
    .NCH(NCH), .DATA_W(DATA_W), .DEPTH(DEPTH), .PKT_W(PKT_W), .DEF_PKT_LEN(256)
  ) dut (
    .clk(clk), .reset(reset), .event_i(event_i), .enable_i(enable_i),
    .ch_en_i(ch_en_i), .pkt_len_i(pkt_len_i), .clear_ovf_i(clear_ovf_i),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .m_axis_tkeep(tkeep), .level_o(level),
    .overflow_o(overflow), .drop_cnt_o(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timestamp: zero in reset, counts while enabled.
  always @(posedge clk) begin
    if (reset) ts_model <= '0;
    else if (enable_i) ts_model <= ts_model + 1'b1;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One-cycle event pulse; returns on the falling edge after the write edge.
  task automatic applyStimulus(input logic [NCH-1:0] ev);
    event_i  = ev;
    exp_word = {ev, ts_model};
    step();
    event_i  = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; event_i = '0; enable_i = 1'b1; ch_en_i = 4'hF;
    pkt_len_i = 32'd256; clear_ovf_i = 1'b0; tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tvalid", 64'(tvalid), 64'd0);
    checkOutput("rst_tlast", 64'(tlast), 64'd0);
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    checkOutput("tkeep", 64'(tkeep), 64'hFF);
    reset = 1'b0;

    // Single event on channel 2 captured with timestamp 10
    repeat (10) step();
    checkOutput("t1_idle_tvalid", 64'(tvalid), 64'd0);
    applyStimulus(4'b0100);
    checkOutput("t1_tvalid", 64'(tvalid), 64'd1);
    checkOutput("t1_tdata", tdata, {4'b0100, 60'd10});
    checkOutput("t1_tlast", 64'(tlast), 64'd0);
    step();
    checkOutput("t1_drained", 64'(tvalid), 64'd0);

    // Simultaneous edges share one word
    applyStimulus(4'b1001);
    checkOutput("t2_tdata", tdata, {4'b1001, 60'd12});
    step();
    checkOutput("t2_level", 64'(level), 64'd0);

    // Disabled channel and disabled capture produce nothing; ts holds while disabled
    ch_en_i = 4'b1110;
    applyStimulus(4'b0001);
    checkOutput("chen_tvalid", 64'(tvalid), 64'd0);
    ch_en_i = 4'hF;
    enable_i = 1'b0;
    applyStimulus(4'b0010);
    checkOutput("en_tvalid", 64'(tvalid), 64'd0);
    step(); step();
    enable_i = 1'b1;
    applyStimulus(4'b0010);
    checkOutput("en_hold_tdata", tdata, {4'b0010, 60'd15});
    step();

    // Packets of 4: tlast on beats 4, 8, 12 (12 proves 2 beats were pending after 10)
    pkt_len_i = 32'd4;
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(4'b0001);
      checkOutput($sformatf("t3_tdata_%0d", i), tdata, exp_word);
      checkOutput($sformatf("t3_tlast_%0d", i), 64'(tlast), 64'((i % 4) == 0));
      step();
    end
    // Length change during beat 2 only applies to the following packet
    for (int i = 1; i <= 7; i++) begin
      if (i == 2) pkt_len_i = 32'd3;
      applyStimulus(4'b0001);
      checkOutput($sformatf("t3b_tlast_%0d", i), 64'(tlast), 64'(i == 4 || i == 7));
      step();
    end
    // Zero length behaves as one-word packets
    pkt_len_i = 32'd0;
    for (int i = 1; i <= 2; i++) begin
      applyStimulus(4'b0001);
      checkOutput($sformatf("len0_tlast_%0d", i), 64'(tlast), 64'd1);
      step();
    end
    pkt_len_i = 32'd4;

    // Backpressure: DEPTH+3 events, 3 dropped
    tready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      applyStimulus(4'b0001);
      if (i < DEPTH) exp_q.push_back(exp_word);
      step();
    end
    checkOutput("t4_level", 64'(level), 64'(DEPTH));
    checkOutput("t4_overflow", 64'(overflow), 64'd1);
    checkOutput("t4_drop_cnt", 64'(drop_cnt), 64'(EXP_DROPS));
    checkOutput("t4_tvalid", 64'(tvalid), 64'd1);
    checkOutput("t4_tdata_hold", tdata, exp_q[0]);
    // Clear together with a drop keeps the flag
    clear_ovf_i = 1'b1;
    applyStimulus(4'b0001);
    clear_ovf_i = 1'b0;
    checkOutput("clr_drop_overflow", 64'(overflow), 64'd1);
    clear_ovf_i = 1'b1;
    step();
    clear_ovf_i = 1'b0;
    checkOutput("clr_overflow", 64'(overflow), 64'd0);
    checkOutput("clr_drop_cnt", 64'(drop_cnt), 64'd0);

    // Full FIFO with a pop in the same cycle accepts the write
    tready = 1'b1;
    applyStimulus(4'b0001);
    tready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(exp_word);
    checkOutput("t5_level", 64'(level), 64'(DEPTH));
    checkOutput("t5_overflow", 64'(overflow), 64'd0);
    checkOutput("t5_drop_cnt", 64'(drop_cnt), 64'd0);
    tready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("t4_drain_valid_%0d", i), 64'(tvalid), 64'd1);
      checkOutput($sformatf("t4_drain_data_%0d", i), tdata, exp_q[i]);
      step();
    end
    checkOutput("t4_empty_tvalid", 64'(tvalid), 64'd0);
    checkOutput("t4_empty_level", 64'(level), 64'd0);

    // Event held high across reset gives no word
    event_i = 4'b0010;
    reset = 1'b1; step(); step(); reset = 1'b0;
    step(); step(); step();
    checkOutput("t6_held_tvalid", 64'(tvalid), 64'd0);
    checkOutput("t6_held_level", 64'(level), 64'd0);
    event_i = '0;
    step();

    // Reset mid-packet drops buffered words and the partial packet
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'b0001);
      step();
    end
    tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'b0001);
      step();
    end
    checkOutput("t6_pre_level", 64'(level), 64'd2);
    reset = 1'b1; step(); reset = 1'b0;
    checkOutput("t6_rst_tvalid", 64'(tvalid), 64'd0);
    checkOutput("t6_rst_level", 64'(level), 64'd0);
    tready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(4'b0001);
      checkOutput($sformatf("t6_tdata_%0d", i), tdata, exp_word);
      checkOutput($sformatf("t6_tlast_%0d", i), 64'(tlast), 64'(i == 4));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
